// File: rtl/mmio_switch.sv
// Registered request/acknowledge MMIO switch: CPU port to SLOTS register windows, a local hole and a default (SDRAM) port.
// Define MMIO_TIMEOUT_EN to build the bus-timeout watchdog (err, err_addr, err_clr).
module mmio_switch #(
  parameter int                       SLOTS        = 8,
  parameter int                       ADDR_W       = 20,
  parameter int                       DATA_W       = 16,
  parameter logic [SLOTS*ADDR_W-1:0]  SLOT_BASE    = '0,
  parameter logic [SLOTS*5-1:0]       SLOT_SZ_LOG2 = '0,
  parameter logic [ADDR_W-1:0]        HOLE_TOP     = ADDR_W'('h1000),
  parameter int                       TIMEOUT      = 255
) (
  input  logic                      cpu_clk,
  input  logic                      rst_in,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      read,
  input  logic                      write,
  input  logic                      instr,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      ready,
  output logic                      read_done,
  output logic [SLOTS-1:0]          s_sel,
  output logic                      s_read,
  output logic                      s_write,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [SLOTS*DATA_W-1:0]   s_rdata,
  input  logic [SLOTS-1:0]          s_ready,
  output logic                      d_read,
  output logic                      d_write,
  input  logic                      d_busy,
  input  logic                      d_ready,
  input  logic [DATA_W-1:0]         d_rdata,
  output logic                      err,
  output logic [ADDR_W-1:0]         err_addr,
  input  logic                      err_clr
);

  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STROBE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] TGT_LOCAL = 2'd0;
  localparam logic [1:0] TGT_DEF   = 2'd1;
  localparam logic [1:0] TGT_SLOT  = 2'd2;

  logic [1:0]        state_reg;
  logic              armed_reg;
  logic              op_wr_reg;
  logic [1:0]        tgt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [ADDR_W-1:0] s_addr_reg;
  logic [DATA_W-1:0] s_wdata_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [SLOTS-1:0]  hit;
  logic [ADDR_W-1:0] slot_off [SLOTS];
  logic [1:0]        dec_tgt;
  logic [IDX_W-1:0]  dec_idx;
  logic [ADDR_W-1:0] dec_off;
  logic              accept;
  logic              wait_done;
  logic              timeout_hit;
  logic [DATA_W-1:0] cap_data;
  logic              slot_active;

  // A slot matches when the address and the (size-aligned) base agree above the window bits.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
      localparam logic [ADDR_W-1:0] BASE = SLOT_BASE[gi*ADDR_W +: ADDR_W];
      localparam int                SZ   = int'(SLOT_SZ_LOG2[gi*5 +: 5]);
      assign hit[gi]      = (addr >> SZ) == (BASE >> SZ);
      assign slot_off[gi] = addr - BASE;
      assign s_sel[gi]    = slot_active && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Scan from the top so the lowest-index matching slot is the one that sticks.
  always_comb begin
    dec_tgt = TGT_DEF;
    dec_idx = '0;
    dec_off = addr;
    if (!instr) begin
      if (addr < HOLE_TOP) dec_tgt = TGT_LOCAL;
      for (int i = SLOTS - 1; i >= 0; i--) begin
        if (hit[i]) begin
          dec_tgt = TGT_SLOT;
          dec_idx = IDX_W'(i);
          dec_off = slot_off[i];
        end
      end
    end
  end

  assign accept    = (state_reg == ST_IDLE) && (read || write) && armed_reg;
  assign wait_done = (tgt_reg == TGT_SLOT) ? s_ready[idx_reg] : (d_ready && !d_busy);
  assign cap_data  = (tgt_reg == TGT_SLOT) ? s_rdata[int'(idx_reg)*DATA_W +: DATA_W] : d_rdata;

  always_ff @(posedge cpu_clk) begin
    if (!rst_in) begin
      state_reg   <= ST_IDLE;
      armed_reg   <= 1'b1;
      op_wr_reg   <= 1'b0;
      tgt_reg     <= TGT_LOCAL;
      idx_reg     <= '0;
      s_addr_reg  <= '0;
      s_wdata_reg <= '0;
      rdata_reg   <= '0;
    end else begin
      if (!read && !write) armed_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            armed_reg   <= 1'b0;
            op_wr_reg   <= write;
            tgt_reg     <= dec_tgt;
            idx_reg     <= dec_idx;
            s_addr_reg  <= dec_off;
            s_wdata_reg <= wdata;
            state_reg   <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (tgt_reg == TGT_LOCAL) begin
            rdata_reg <= '0;
            state_reg <= ST_DONE;
          end else begin
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            rdata_reg <= cap_data;
            state_reg <= ST_DONE;
          end else if (timeout_hit) begin
            rdata_reg <= '1;
            state_reg <= ST_DONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [7:0]        cnt_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] err_addr_reg;
  logic [ADDR_W-1:0] req_addr_reg;

  assign timeout_hit = (state_reg == ST_WAIT) && !wait_done && (cnt_reg == TIMEOUT_C);

  // A new timeout outranks err_clr in the same cycle; err_addr keeps the first offender.
  always_ff @(posedge cpu_clk) begin
    if (!rst_in) begin
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
      req_addr_reg <= '0;
    end else begin
      if (accept) req_addr_reg <= addr;
      if (state_reg == ST_STROBE) cnt_reg <= '0;
      else if (state_reg == ST_WAIT) cnt_reg <= cnt_reg + 8'd1;
      if (timeout_hit) begin
        err_reg <= 1'b1;
        if (!err_reg) err_addr_reg <= req_addr_reg;
      end else if (err_clr) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign err      = err_reg;
  assign err_addr = err_addr_reg;
`else
  logic unused_cfg;
  assign unused_cfg  = err_clr ^ (|8'(TIMEOUT));
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
  assign err_addr    = '0;
`endif

  assign slot_active = (state_reg != ST_IDLE) && (tgt_reg == TGT_SLOT);
  assign busy        = (state_reg != ST_IDLE);
  assign ready       = (state_reg == ST_DONE);
  assign read_done   = ready && !op_wr_reg;
  assign rdata       = rdata_reg;
  assign s_addr      = s_addr_reg;
  assign s_wdata     = s_wdata_reg;
  assign s_read      = (state_reg == ST_STROBE) && (tgt_reg == TGT_SLOT) && !op_wr_reg;
  assign s_write     = (state_reg == ST_STROBE) && (tgt_reg == TGT_SLOT) && op_wr_reg;
  assign d_read      = (state_reg == ST_STROBE) && (tgt_reg == TGT_DEF) && !op_wr_reg;
  assign d_write     = (state_reg == ST_STROBE) && (tgt_reg == TGT_DEF) && op_wr_reg;

endmodule

// File: tb/tb_mmio_switch.sv
// Directed, table-driven bench for mmio_switch with four slots, a local hole and the default port.
module tb_mmio_switch;

  localparam int SLOTS  = 4;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  logic                    cpu_clk = 1'b0;
  logic                    rst_in;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       wdata;
  logic                    read, write, instr;
  logic [DATA_W-1:0]       rdata;
  logic                    busy, ready, read_done;
  logic [SLOTS-1:0]        s_sel;
  logic                    s_read, s_write;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [SLOTS*DATA_W-1:0] s_rdata;
  logic [SLOTS-1:0]        s_ready;
  logic                    d_read, d_write, d_busy, d_ready;
  logic [DATA_W-1:0]       d_rdata;
  logic                    err;
  logic [ADDR_W-1:0]       err_addr;
  logic                    err_clr;

  int checks = 0;
  int errors = 0;

  always #5 cpu_clk = ~cpu_clk;

  // slot0 0x000-0x007, slot1 0x000-0x00F (shadowed by slot0), slot2 0x010-0x013, slot3 0x100-0x1FF
  mmio_switch #(
    .SLOTS(SLOTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SLOT_BASE({20'h00100, 20'h00010, 20'h00000, 20'h00000}),
    .SLOT_SZ_LOG2({5'd8, 5'd2, 5'd4, 5'd3}),
    .HOLE_TOP(20'h01000),
    .TIMEOUT(8)
  ) dut (
    .cpu_clk(cpu_clk), .rst_in(rst_in), .addr(addr), .wdata(wdata),
    .read(read), .write(write), .instr(instr), .rdata(rdata), .busy(busy),
    .ready(ready), .read_done(read_done), .s_sel(s_sel), .s_read(s_read),
    .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .s_ready(s_ready), .d_read(d_read), .d_write(d_write), .d_busy(d_busy),
    .d_ready(d_ready), .d_rdata(d_rdata), .err(err), .err_addr(err_addr),
    .err_clr(err_clr)
  );

  typedef struct {
    logic [19:0] addr;
    logic [15:0] wdata;
    logic        rd, wr, ins;
    int          wait_cyc;
    logic [3:0]  exp_sel;
    logic [19:0] exp_saddr;
    logic [3:0]  exp_strb;   // {s_read, s_write, d_read, d_write}
    int          exp_lat;
    logic        chk_rdata;
    logic [15:0] exp_rdata;
    logic        exp_rdone;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [19:0] a, input logic [15:0] wd, input logic rd,
                              input logic wr, input logic ins, input int wc, input logic [3:0] sel,
                              input logic [19:0] sa, input logic [3:0] strb, input int lat,
                              input logic crd, input logic [15:0] rdv, input logic rdn);
    vec_t v;
    v.addr = a; v.wdata = wd; v.rd = rd; v.wr = wr; v.ins = ins; v.wait_cyc = wc;
    v.exp_sel = sel; v.exp_saddr = sa; v.exp_strb = strb; v.exp_lat = lat;
    v.chk_rdata = crd; v.exp_rdata = rdv; v.exp_rdone = rdn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input string tag, input vec_t v);
    int lat = 0;
    int nstrb = 0;
    logic [3:0] strb_or = '0;
    logic [3:0] strb;
    @(negedge cpu_clk);
    addr = v.addr; wdata = v.wdata; read = v.rd; write = v.wr; instr = v.ins;
    s_ready = (v.wait_cyc == 0) ? 4'hF : 4'h0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge cpu_clk);
      if (c == 1) begin
        read = 1'b0; write = 1'b0; instr = 1'b0;
        chk({tag, "_sel"}, 32'(s_sel), 32'(v.exp_sel));
        chk({tag, "_saddr"}, 32'(s_addr), 32'(v.exp_saddr));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (v.wr) chk({tag, "_swdata"}, 32'(s_wdata), 32'(v.wdata));
      end
      strb = {s_read, s_write, d_read, d_write};
      if (strb != 4'd0) begin
        nstrb++;
        strb_or |= strb;
      end
      if (ready) begin
        lat = c;
        if (v.chk_rdata) chk({tag, "_rdata"}, 32'(rdata), 32'(v.exp_rdata));
        chk({tag, "_rdone"}, 32'(read_done), 32'(v.exp_rdone));
      end
      if (v.wait_cyc != 0 && c == v.wait_cyc) s_ready = 4'hF;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_strb"}, 32'(strb_or), 32'(v.exp_strb));
    chk({tag, "_nstrb"}, 32'(nstrb), (v.exp_strb == 4'd0) ? 32'd0 : 32'd1);
    @(negedge cpu_clk);
    chk({tag, "_idle"}, 32'({busy, ready}), 32'd0);
    $display("%s addr=%05h rd=%0b wr=%0b instr=%0b lat=%0d rdata=%04h", tag, v.addr, v.rd, v.wr,
             v.ins, lat, rdata);
  endtask

  initial begin
    int nrdy;
    int nstb;
    vec_t tv;

    vecs[0] = mk(20'h00012, 16'h0000, 1, 0, 0, 0, 4'b0100, 20'h2,    4'b1000, 3, 1, 16'hBEEF, 1);
    vecs[1] = mk(20'h00006, 16'h1234, 0, 1, 0, 5, 4'b0001, 20'h6,    4'b0100, 6, 0, 16'h0000, 0);
    vecs[2] = mk(20'h0000A, 16'h0000, 1, 0, 0, 0, 4'b0010, 20'hA,    4'b1000, 3, 1, 16'h1111, 1);
    vecs[3] = mk(20'h00003, 16'h0000, 1, 0, 1, 0, 4'b0000, 20'h3,    4'b0010, 3, 1, 16'hD00D, 1);
    vecs[4] = mk(20'h00800, 16'h0000, 1, 0, 0, 0, 4'b0000, 20'h800,  4'b0000, 2, 1, 16'h0000, 1);
    vecs[5] = mk(20'h05000, 16'h0000, 1, 0, 0, 0, 4'b0000, 20'h5000, 4'b0010, 3, 1, 16'hD00D, 1);
    vecs[6] = mk(20'h00104, 16'h5A5A, 0, 1, 0, 0, 4'b1000, 20'h4,    4'b0100, 3, 0, 16'h0000, 0);
    vecs[7] = mk(20'h00900, 16'h7777, 0, 1, 0, 0, 4'b0000, 20'h900,  4'b0000, 2, 0, 16'h0000, 0);
    vecs[8] = mk(20'h00013, 16'h4321, 1, 1, 0, 0, 4'b0100, 20'h3,    4'b0100, 3, 0, 16'h0000, 0);
    vecs[9] = mk(20'h08000, 16'hCAFE, 0, 1, 0, 0, 4'b0000, 20'h8000, 4'b0001, 3, 0, 16'h0000, 0);

    rst_in = 1'b0; addr = '0; wdata = '0; read = 0; write = 0; instr = 0;
    s_rdata = {16'h3333, 16'hBEEF, 16'h1111, 16'h0A0A}; s_ready = 4'hF;
    d_busy = 1'b0; d_ready = 1'b1; d_rdata = 16'hD00D; err_clr = 1'b0;
    repeat (3) @(negedge cpu_clk);
    chk("rst_ctl", 32'({busy, ready, read_done, s_read, s_write, d_read, d_write, err}), 32'd0);
    chk("rst_data", 32'({rdata, s_wdata}), 32'd0);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_sel", 32'(s_sel), 32'd0);
    chk("rst_erraddr", 32'(err_addr), 32'd0);
    rst_in = 1'b1;

    for (int i = 0; i < 10; i++) do_txn($sformatf("t%0d", i), vecs[i]);

    // Held read: one transaction, then a one-cycle drop re-arms.
    @(negedge cpu_clk);
    addr = 20'h00012; read = 1'b1; s_ready = 4'hF;
    nrdy = 0; nstb = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge cpu_clk);
      if (ready) nrdy++;
      if (s_read) nstb++;
    end
    chk("rearm_ready", 32'(nrdy), 32'd1);
    chk("rearm_strobe", 32'(nstb), 32'd1);
    read = 1'b0;
    @(negedge cpu_clk);
    chk("rearm_idle", 32'(busy), 32'd0);
    $display("rearm held read: ready pulses=%0d strobes=%0d", nrdy, nstb);
    do_txn("rearm_next", vecs[2]);

    // Reset in WAIT aborts without ready.
    @(negedge cpu_clk);
    addr = 20'h00006; write = 1'b1; wdata = 16'h9999; s_ready = 4'h0;
    @(negedge cpu_clk);
    write = 1'b0;
    @(negedge cpu_clk);
    chk("abort_inwait", 32'(busy), 32'd1);
    rst_in = 1'b0;
    @(negedge cpu_clk);
    chk("abort_state", 32'({busy, ready, s_sel}), 32'd0);
    rst_in = 1'b1;
    nrdy = 0;
    repeat (3) begin
      @(negedge cpu_clk);
      if (ready) nrdy++;
    end
    chk("abort_noready", 32'(nrdy), 32'd0);
    $display("reset abort: ready pulses after abort=%0d", nrdy);
    do_txn("abort_next", vecs[0]);

`ifdef MMIO_TIMEOUT_EN
    tv = mk(20'h00012, 16'h0000, 1, 0, 0, 99, 4'b0100, 20'h2, 4'b1000, 11, 1, 16'hFFFF, 1);
    do_txn("to1", tv);
    chk("to1_err", 32'(err), 32'd1);
    chk("to1_erraddr", 32'(err_addr), 32'h12);
    tv = mk(20'h00013, 16'h0000, 1, 0, 0, 99, 4'b0100, 20'h3, 4'b1000, 11, 1, 16'hFFFF, 1);
    do_txn("to2", tv);
    chk("to2_err", 32'(err), 32'd1);
    chk("to2_erraddr", 32'(err_addr), 32'h12);
    err_clr = 1'b1;
    @(negedge cpu_clk);
    err_clr = 1'b0;
    chk("to_clr", 32'(err), 32'd0);
    $display("timeout: err cleared, err_addr=%05h", err_addr);
`else
    tv = vecs[1];
    err_clr = 1'b1;
    do_txn("noto", tv);
    err_clr = 1'b0;
    chk("noto_err", 32'({err, err_addr}), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_switch.md
# mmio_switch

Parametrised memory-mapped I/O switch between the CPU data port and up to SLOTS peripheral register windows, with a fallthrough default port for SDRAM. It replaces hand-written if/else address decode in the top level with a registered request/acknowledge engine. Features: programmable per-slot base and size, wait-state handshake, a read-done pulse for side-effecting reads, and a bus-timeout watchdog. It sits between `cpu` and the peripherals (uart, spi, irq_ctrl, timer, vga, sdram).

## Interface
- SLOTS, 8: number of peripheral windows (1..16).
- ADDR_W, 20: CPU address width.
- DATA_W, 16: data width.
- SLOT_BASE, 0: SLOTS*ADDR_W flat vector; slot i base at bits [i*ADDR_W +: ADDR_W]; base must be aligned to the slot size.
- SLOT_SZ_LOG2, 0: SLOTS*5 flat vector; slot i spans 2^SLOT_SZ_LOG2[i] words.
- HOLE_TOP, 20'h1000: unmapped non-slot addresses below this value complete locally; all others go to the default port.
- TIMEOUT, 255: wait cycles before a bus error (8-bit counter).
- cpu_clk in 1: single clock; all logic on rising edge.
- rst_in in 1: synchronous, active-low reset.
- addr, wdata in ADDR_W, DATA_W: CPU address and write data.
- read, write, instr in 1: CPU request; instr=1 forces the default port.
- rdata out DATA_W: registered read data, valid while ready=1.
- busy out 1: transaction in flight.
- ready out 1: one-cycle completion pulse.
- read_done out 1: one-cycle pulse with ready on completed reads.
- s_sel out SLOTS: one-hot slot select, held for the whole transaction.
- s_read, s_write out 1: one-cycle strobes to the selected slot.
- s_addr out ADDR_W: addr minus the slot base (offset).
- s_wdata out DATA_W: latched write data.
- s_rdata in SLOTS*DATA_W: per-slot read data.
- s_ready in SLOTS: per-slot completion; a slot with no wait states ties this high.
- d_read, d_write out 1: default-port strobes (one cycle).
- d_busy, d_ready in 1: default-port handshake.
- d_rdata in DATA_W: default-port data.
- err out 1: sticky bus-error flag.
- err_addr out ADDR_W: address of the first timed-out access.
- err_clr in 1: clears err.

## Operation
- States are IDLE, STROBE, WAIT, DONE.
- **IDLE**: accepts when (read|write) and armed=1. On accept:
  - latches addr, wdata, instr and the operation; write has priority if read and write are both high.
  - decodes the target, clears armed, and goes to STROBE.
  - armed is set in any cycle where read=write=0.
- **Decode**:
  - instr=1 selects the default port.
  - Otherwise the lowest-index slot with (addr>>SZ)==(BASE>>SZ) wins.
  - Otherwise an address below HOLE_TOP selects LOCAL.
  - Otherwise the default port is selected.
- **STROBE** (one cycle): asserts s_read/s_write or d_read/d_write. LOCAL goes directly to DONE with rdata=0. Others go to WAIT.
- **WAIT**:
  - Slot targets complete on s_ready[sel].
  - Default targets complete on d_ready while d_busy=0.
  - On completion, rdata is captured and the state goes to DONE.
- **DONE** (one cycle): ready=1; read_done=1 if the operation was a read; then IDLE.
- **Timeout** (see Configuration):
  - The counter starts at 0 in STROBE and increments in WAIT.
  - When it reaches TIMEOUT, the state goes to DONE with rdata = all ones.
  - err is set; err_addr is loaded only if err was 0.
- err_clr clears err; a simultaneous new error wins (err stays 1).
- s_sel and s_addr are held from STROBE through DONE; s_sel=0 in IDLE.

## Timing
- Reset (rst_in=0 at a clock edge): state=IDLE, armed=1, and every output is 0 (rdata, s_sel, s_addr, s_wdata, err_addr, err included).
- Reset mid-transaction aborts the transaction; no ready is issued.
- Zero-wait slot: request sampled at edge N; strobe in N+1; WAIT sees s_ready in N+2; ready in N+3.
- LOCAL: ready in N+2.
- busy=1 from the accept edge through DONE inclusive.
- Requests outside IDLE are ignored. A request held high through DONE is not re-accepted until it drops for one cycle.
- Bus error occurs at most TIMEOUT+3 cycles after the request.

## Configuration
- `MMIO_TIMEOUT_EN` defined: the watchdog, err, err_addr and err_clr are active as described.
- Undefined: WAIT waits indefinitely, err=0, err_addr=0, err_clr is ignored, and no counter is synthesised.

## Test plan
- **Slot read:** SLOTS=4, slot2 base 0x0010 size 4; read 0x0012 with s_rdata2=0xBEEF and s_ready tied 1.
  - s_sel=0100 and s_addr=2.
  - ready and read_done are pulsed 3 cycles after the request.
  - rdata=0xBEEF.
- **Write with wait states:** write 0x0006 with wdata 0x1234; s_ready held low for 5 cycles.
  - One s_write pulse with s_wdata=0x1234.
  - ready follows s_ready by one cycle.
  - read_done=0.
- **Routing:** instr=1 at 0x0003 goes to the default port (d_read pulse); 0x0800 (LOCAL) gives ready after 2 cycles with rdata=0; 0x5000 goes to the default port.
- **Timeout** (TIMEOUT=8, `MMIO_TIMEOUT_EN` defined): read a slot with s_ready=0.
  - ready arrives at request+11 with rdata=0xFFFF, err=1 and err_addr latched.
  - A second timeout keeps the first err_addr.
  - err_clr clears err.
- **Re-arm and priority:** read held high across two completions yields exactly one transaction; read and write high together perform a write with read_done=0.
- **Reset abort:** assert rst_in=0 in WAIT.
  - The next edge gives IDLE, s_sel=0, busy=0 and no ready.
  - After release, a new request completes normally.
